// File: rtl/camera_pkg.sv
// Shared types and defaults for the camera capture sequencer.
package camera_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        CAPTURING = 2'd2,
        DONE      = 2'd3
    } capture_state_t;

    // 200x200 pixels at 8 bpp.
    localparam int CAPTURE_BYTES_DEFAULT = 40000;
    localparam int ADDRESS_WIDTH_DEFAULT = 14;

endpackage

// File: rtl/frame_valid_monitor.sv
// Edge detector for the sensor frame-valid level.
// CAMERA_FRAME_VALID_SYNC_EN adds a 2-flop synchronizer ahead of the edge detector.
module frame_valid_monitor (
    input  logic clock_spi_in,
    input  logic reset_spi_n_in,
    input  logic frame_valid_in,
    output logic rise_out,
    output logic fall_out
);

    logic level;
    logic level_q;

`ifdef CAMERA_FRAME_VALID_SYNC_EN
    logic sync_meta;

    always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
        if (!reset_spi_n_in) begin
            sync_meta <= 1'b0;
            level     <= 1'b0;
        end else begin
            sync_meta <= frame_valid_in;
            level     <= sync_meta;
        end
    end
`else
    assign level = frame_valid_in;
`endif

    always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
        if (!reset_spi_n_in) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise_out = level & ~level_q;
    assign fall_out = ~level & level_q;

endmodule

// File: rtl/camera_capture_sequencer.sv
// Sequences one still capture into the frame buffer and its byte-wise SPI readback.
// Build option: CAMERA_FRAME_VALID_SYNC_EN (synchronize frame_valid_in, see frame_valid_monitor).
module camera_capture_sequencer
    import camera_pkg::*;
#(
    parameter int CAPTURE_BYTES = CAPTURE_BYTES_DEFAULT,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT
) (
    input  logic                     clock_spi_in,
    input  logic                     reset_spi_n_in,
    input  logic                     capture_request_in,
    input  logic                     abort_in,
    input  logic                     frame_valid_in,
    input  logic                     pixel_word_valid_in,
    input  logic [31:0]              pixel_word_in,
    input  logic                     read_next_in,
    output logic                     buffer_write_enable_out,
    output logic [ADDRESS_WIDTH-1:0] buffer_write_address_out,
    output logic [31:0]              buffer_write_data_out,
    output logic [ADDRESS_WIDTH-1:0] buffer_read_address_out,
    output logic [1:0]               byte_select_out,
    output logic [15:0]              bytes_remaining_out,
    output logic                     capture_busy_out,
    output logic                     overflow_out,
    output capture_state_t           capture_state_out
);

    localparam logic [15:0] WORD_LIMIT = 16'(CAPTURE_BYTES / 4);

    capture_state_t state;
    logic [15:0]    word_count;
    logic [15:0]    words_after;
    logic [15:0]    bytes_read;
    logic [15:0]    captured_bytes;
    logic           frame_rise;
    logic           frame_fall;
    logic           write_accept;
    logic           read_advance;

    frame_valid_monitor u_frame_valid_monitor (
        .clock_spi_in   (clock_spi_in),
        .reset_spi_n_in (reset_spi_n_in),
        .frame_valid_in (frame_valid_in),
        .rise_out       (frame_rise),
        .fall_out       (frame_fall)
    );

    // Strobes and pulses carry no backpressure: each high cycle of
    // pixel_word_valid_in, read_next_in, capture_request_in or abort_in is one event.
    assign write_accept = (state == CAPTURING) && pixel_word_valid_in && (word_count < WORD_LIMIT);
    assign read_advance = (state == DONE) && read_next_in && (bytes_read < captured_bytes);
    assign words_after  = word_count + {15'd0, write_accept};

    assign buffer_read_address_out = ADDRESS_WIDTH'(bytes_read >> 2);
    assign byte_select_out         = bytes_read[1:0];
    assign capture_state_out       = state;

    always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
        if (!reset_spi_n_in) begin
            state                    <= IDLE;
            word_count               <= '0;
            bytes_read               <= '0;
            captured_bytes           <= '0;
            buffer_write_enable_out  <= 1'b0;
            buffer_write_address_out <= '0;
            buffer_write_data_out    <= '0;
            bytes_remaining_out      <= '0;
            capture_busy_out         <= 1'b0;
            overflow_out             <= 1'b0;
        end else begin
            buffer_write_enable_out <= 1'b0;
            if (abort_in) begin
                state               <= IDLE;
                word_count          <= '0;
                bytes_read          <= '0;
                captured_bytes      <= '0;
                bytes_remaining_out <= '0;
                capture_busy_out    <= 1'b0;
                overflow_out        <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (capture_request_in) begin
                            state               <= ARMED;
                            word_count          <= '0;
                            bytes_read          <= '0;
                            captured_bytes      <= '0;
                            bytes_remaining_out <= '0;
                            capture_busy_out    <= 1'b1;
                            overflow_out        <= 1'b0;
                        end else if (read_advance) begin
                            bytes_read          <= bytes_read + 16'd1;
                            bytes_remaining_out <= bytes_remaining_out - 16'd1;
                        end
                    end
                    ARMED: begin
                        if (frame_rise) begin
                            state <= CAPTURING;
                        end
                    end
                    CAPTURING: begin
                        if (write_accept) begin
                            buffer_write_enable_out  <= 1'b1;
                            buffer_write_address_out <= ADDRESS_WIDTH'(word_count);
                            buffer_write_data_out    <= pixel_word_in;
                            word_count               <= words_after;
                        end else if (pixel_word_valid_in) begin
                            overflow_out <= 1'b1;
                        end
                        // A strobe coincident with the falling edge is counted in words_after.
                        if (frame_fall) begin
                            state               <= DONE;
                            capture_busy_out    <= 1'b0;
                            captured_bytes      <= words_after << 2;
                            bytes_remaining_out <= words_after << 2;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// Randomized self-checking bench for camera_capture_sequencer against a behavioural capture model.
`timescale 1ns/1ps
module tb_camera_capture_sequencer;
    import camera_pkg::*;

    localparam int WORDS = 10000;
`ifdef CAMERA_FRAME_VALID_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif
    localparam int LAT = 1 + SYNC_DLY;

    // ---------------- clock / reset / DUT ----------------
    logic           clock_spi_in = 1'b0;
    logic           reset_spi_n_in = 1'b0;
    logic           capture_request_in = 1'b0;
    logic           abort_in = 1'b0;
    logic           frame_valid_in = 1'b0;
    logic           pixel_word_valid_in = 1'b0;
    logic [31:0]    pixel_word_in = '0;
    logic           read_next_in = 1'b0;
    logic           buffer_write_enable_out;
    logic [13:0]    buffer_write_address_out;
    logic [31:0]    buffer_write_data_out;
    logic [13:0]    buffer_read_address_out;
    logic [1:0]     byte_select_out;
    logic [15:0]    bytes_remaining_out;
    logic           capture_busy_out;
    logic           overflow_out;
    capture_state_t capture_state_out;

    always #7 clock_spi_in = ~clock_spi_in;

    camera_capture_sequencer dut (
        .clock_spi_in             (clock_spi_in),
        .reset_spi_n_in           (reset_spi_n_in),
        .capture_request_in       (capture_request_in),
        .abort_in                 (abort_in),
        .frame_valid_in           (frame_valid_in),
        .pixel_word_valid_in      (pixel_word_valid_in),
        .pixel_word_in            (pixel_word_in),
        .read_next_in             (read_next_in),
        .buffer_write_enable_out  (buffer_write_enable_out),
        .buffer_write_address_out (buffer_write_address_out),
        .buffer_write_data_out    (buffer_write_data_out),
        .buffer_read_address_out  (buffer_read_address_out),
        .byte_select_out          (byte_select_out),
        .bytes_remaining_out      (bytes_remaining_out),
        .capture_busy_out         (capture_busy_out),
        .overflow_out             (overflow_out),
        .capture_state_out        (capture_state_out)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    capture_state_t m_st = IDLE;
    int             m_words = 0;
    int             m_captured = 0;
    int             m_read = 0;
    bit             m_ovf = 1'b0;
    bit             m_we = 1'b0;
    logic [3:0]     m_fvh = '0;      // m_fvh[j]: frame_valid_in j cycles ago
    logic [45:0]    exp_q[$];        // {address, data} of writes still to appear
    int             wr_hits[16384];
    int             last_waddr = -1;

    task automatic model_clear();
        m_words = 0; m_captured = 0; m_read = 0; m_ovf = 1'b0;
    endtask

    task automatic model_step();
        bit rise, fall;
        m_fvh = {m_fvh[2:0], frame_valid_in};
        rise  = m_fvh[SYNC_DLY] && !m_fvh[SYNC_DLY+1];
        fall  = !m_fvh[SYNC_DLY] && m_fvh[SYNC_DLY+1];
        m_we  = 1'b0;
        if (abort_in) begin
            m_st = IDLE;
            model_clear();
        end else if (m_st == IDLE || m_st == DONE) begin
            if (capture_request_in) begin
                m_st = ARMED;
                model_clear();
            end else if (m_st == DONE && read_next_in && m_read < m_captured) begin
                m_read++;
            end
        end else if (m_st == ARMED) begin
            if (rise) m_st = CAPTURING;
        end else begin
            if (pixel_word_valid_in) begin
                if (m_words < WORDS) begin
                    exp_q.push_back({14'(m_words), pixel_word_in});
                    m_we = 1'b1;
                    m_words++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (fall) begin
                m_st = DONE;
                m_captured = m_words * 4;
            end
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clock_spi_in) begin
        logic [45:0] w;
        int          exp_rem;
        if (!reset_spi_n_in) begin
            m_st = IDLE; model_clear(); m_we = 1'b0; m_fvh = '0;
            exp_q.delete();
            check("reset_outputs_zero", {31'd0, |{buffer_write_enable_out, buffer_write_address_out,
                  buffer_write_data_out, buffer_read_address_out, byte_select_out, bytes_remaining_out,
                  capture_busy_out, overflow_out, capture_state_out}}, 32'd0);
        end else begin
            exp_rem = (m_st == DONE) ? (m_captured - m_read) : 0;
            check("state", capture_state_out, m_st);
            check("write_enable", buffer_write_enable_out, m_we);
            if (buffer_write_enable_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("write_address", buffer_write_address_out, w[45:32]);
                    check("write_data", buffer_write_data_out, w[31:0]);
                end
                wr_hits[buffer_write_address_out]++;
                last_waddr = buffer_write_address_out;
            end
            check("read_address", buffer_read_address_out, m_read / 4);
            check("byte_select", byte_select_out, m_read % 4);
            check("bytes_remaining", bytes_remaining_out, exp_rem);
            check("capture_busy", capture_busy_out, (m_st == ARMED || m_st == CAPTURING));
            check("overflow", overflow_out, m_ovf);
            model_step();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock_spi_in);
        #1;
    endtask

    task automatic cycle(input bit req, input bit ab, input bit pv, input bit rn);
        capture_request_in  = req;
        abort_in            = ab;
        pixel_word_valid_in = pv;
        read_next_in        = rn;
        pixel_word_in       = $urandom();
        tick();
        capture_request_in = 1'b0; abort_in = 1'b0; pixel_word_valid_in = 1'b0; read_next_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic stream(input int n);
        int sent = 0;
        while (sent < n) begin
            bit go = ($urandom_range(0, 7) != 0);
            cycle(0, 0, go, 0);
            if (go) sent++;
        end
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1);
    endtask

    task automatic capture_frame(input int n);
        frame_valid_in = 1'b1;
        idle(LAT);
        stream(n);
        frame_valid_in = 1'b0;
        idle(SYNC_DLY + 3);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int bad_hits;
        int n;
        idle(3);
        reset_spi_n_in = 1'b1;
        idle(2);
        check("lit_reset_state", capture_state_out, IDLE);
        check("lit_reset_remaining", bytes_remaining_out, 0);

        // nominal capture
        foreach (wr_hits[i]) wr_hits[i] = 0;
        cycle(1, 0, 0, 0);
        idle(3);
        check("lit_armed_busy", capture_busy_out, 1);
        capture_frame(WORDS);
        bad_hits = 0;
        foreach (wr_hits[i]) if (wr_hits[i] != ((i < WORDS) ? 1 : 0)) bad_hits++;
        check("lit_each_address_once", bad_hits, 0);
        check("lit_nominal_done", capture_state_out, DONE);
        check("lit_nominal_remaining", bytes_remaining_out, 40000);
        check("lit_nominal_overflow", overflow_out, 0);
        check("lit_model_captured", m_captured, 40000);

        // readback
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 1);
            idle($urandom_range(0, 2));
        end
        check("lit_read_address_6", buffer_read_address_out, 1);
        check("lit_byte_select_6", byte_select_out, 2);
        check("lit_remaining_6", bytes_remaining_out, 39994);
        reads(39994);
        check("lit_remaining_end", bytes_remaining_out, 0);
        check("lit_read_address_end", buffer_read_address_out, 10000);
        reads(5);
        check("lit_remaining_saturated", bytes_remaining_out, 0);

        // overflow
        last_waddr = -1;
        cycle(1, 0, 0, 0);
        idle(2);
        capture_frame(WORDS + 5);
        check("lit_overflow_last_addr", last_waddr, 9999);
        check("lit_overflow_flag", overflow_out, 1);
        check("lit_overflow_remaining", bytes_remaining_out, 40000);

        // request coincident with the detected rising edge skips that frame
        frame_valid_in = 1'b1;
        idle(SYNC_DLY);
        cycle(1, 0, 0, 0);
        stream(30);
        check("lit_skipped_frame_armed", capture_state_out, ARMED);
        frame_valid_in = 1'b0;
        idle(SYNC_DLY + 3);
        frame_valid_in = 1'b1;
        idle(LAT);
        stream(10);
        cycle(1, 0, 0, 0);
        stream(10);
        frame_valid_in = 1'b0;
        idle(SYNC_DLY + 3);
        check("lit_second_frame_done", capture_state_out, DONE);
        check("lit_second_frame_remaining", bytes_remaining_out, 80);

        // abort wins over a simultaneous request
        cycle(1, 1, 0, 0);
        idle(1);
        check("lit_abort_idle", capture_state_out, IDLE);
        check("lit_abort_remaining", bytes_remaining_out, 0);

        // edge-to-state latency, then abort mid-capture
        cycle(1, 0, 0, 0);
        idle(3);
        frame_valid_in = 1'b1;
        n = 0;
        do begin
            cycle(0, 0, 0, 0);
            n++;
        end while (capture_state_out != CAPTURING && n < 10);
        check("lit_edge_latency", n, LAT);
        stream(20);
        cycle(0, 1, 1, 0);
        check("lit_abort_capture_idle", capture_state_out, IDLE);
        frame_valid_in = 1'b0;
        idle(4);

        // reset in the middle of a capture
        cycle(1, 0, 0, 0);
        frame_valid_in = 1'b1;
        idle(LAT);
        stream(50);
        reset_spi_n_in = 1'b0;
        pixel_word_valid_in = 1'b1;
        #2;
        check("lit_async_reset_state", capture_state_out, IDLE);
        check("lit_async_reset_busy", capture_busy_out, 0);
        tick();
        cycle(0, 0, 1, 0);
        reset_spi_n_in = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        check("lit_no_write_after_reset", buffer_write_enable_out, 0);
        frame_valid_in = 1'b0;
        idle(4);

        // randomized short captures with random reads and occasional aborts
        for (int k = 0; k < 6; k++) begin
            cycle(1, 0, 0, 0);
            idle($urandom_range(0, 4));
            capture_frame($urandom_range(1, 40));
            n = $urandom_range(0, 200);
            for (int i = 0; i < n; i++) cycle(0, ($urandom_range(0, 150) == 0), 0, $urandom_range(0, 1));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
